// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the responder FSM state type.
package wb_pkg;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slv_state_e;
endpackage

// File: rtl/sram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module sram_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [SEL_W-1:0]         be,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < SEL_W; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder over a word-addressed SRAM with programmable wait states.
// Define WB_SRAM_ERR_EN to answer out-of-window or misaligned requests with an err pulse.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                   DEPTH       = 1024,
    parameter int                   WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WB_ADDR_W-1:0] wb_adr_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    wb_slv_state_e        state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic                 req, accept;
    logic [WB_ADDR_W-1:0] offset;
    logic [AW-1:0]        idx_req, idx_q, ram_addr;
    logic                 bad_req, err_q, we_q, ram_we;
    logic [WB_SEL_W-1:0]  sel_q;
    logic [WB_DATA_W-1:0] dat_q, ram_rdata;

    assign req     = wb_cyc_i & wb_stb_i;
    assign accept  = (state == IDLE) && req;
    assign offset  = wb_adr_i - BASE_ADDR;
    assign idx_req = offset[AW+1:2];

`ifdef WB_SRAM_ERR_EN
    // Window is DEPTH*4 aligned, so any offset bit above the window means out of range.
    assign bad_req = ((offset >> (AW + 2)) != '0) || (offset[1:0] != 2'b00);
`else
    logic unused_offset;
    assign bad_req       = 1'b0;
    assign unused_offset = ^{offset[WB_ADDR_W-1:AW+2], offset[1:0]};
`endif

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request fields are captured once at acceptance; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= idx_req;
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
            err_q <= bad_req;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wb_ack_o  = 1'b0;
        wb_err_o  = 1'b0;
        wb_dat_o  = '0;
        ram_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                wb_ack_o  = !err_q;
                wb_err_o  = err_q;
                ram_we    = we_q && !err_q;
                if (!we_q && !err_q) begin
                    wb_dat_o = ram_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The RAM reads the live address while idle so read data is ready in RESP with zero waits.
    assign ram_addr = (state == IDLE) ? idx_req : idx_q;

    sram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (WB_DATA_W),
        .SEL_W  (WB_SEL_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (sel_q),
        .wdata (dat_q),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: one zero-wait and one three-wait instance.
module tb_wb_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [31:0] adr   [2];
    logic [3:0]  sel   [2];
    logic [31:0] dat_i [2];
    logic [31:0] dat_o [2];
    logic        ack   [2];
    logic        err   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_sram_slave #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_i(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dat_i[0]),
        .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
    );

    wb_sram_slave #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_i(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dat_i[1]),
        .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
    );

    task automatic drive(input int d, input bit w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_i[d] = wd;
    endtask

    task automatic release_bus(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    // One transfer; lat counts cycles with the stb-assert cycle as 1 (0 on timeout).
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input bit scramble,
                        output logic [31:0] rd, output bit got_ack, output bit got_err,
                        output int lat);
        @(posedge clk); #1;
        drive(d, w, a, s, wd);
        rd = '0; got_ack = 1'b0; got_err = 1'b0; lat = 0;
        for (int k = 2; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ack[d] || err[d]) begin
                got_ack = ack[d]; got_err = err[d]; rd = dat_o[d]; lat = k;
                break;
            end
            if (scramble && k == 2) begin
                adr[d] = a ^ 32'h0000_0FF0; dat_i[d] = ~wd; sel[d] = ~s; we[d] = ~w;
            end
        end
        release_bus(0 + d);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        release_bus(0); release_bus(1);
        for (int d = 0; d < 2; d++) begin adr[d] = '0; sel[d] = '0; dat_i[d] = '0; end
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b want 0", d, ack[d]); end
            checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
            checks++; if (dat_o[d] !== 32'h0) begin errors++; $display("FAIL reset_dat[%0d]: got %h want 0", d, dat_o[d]); end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] r; bit a, e; int l;
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, r, a, e, l);
        checks++; if (!(a && !e && l == 2)) begin errors++; $display("FAIL w0_write: ack=%b err=%b lat=%0d want 1 0 2", a, e, l); end
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (!(a && !e && l == 2)) begin errors++; $display("FAIL w0_read_lat: ack=%b err=%b lat=%0d want 1 0 2", a, e, l); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL w0_read_data: got %h want deadbeef", r); end
        @(posedge clk); #1;
        checks++; if (dat_o[0] !== 32'h0) begin errors++; $display("FAIL dat_idle: got %h want 0", dat_o[0]); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] r; bit a, e; int l;
        xfer(0, 1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0, r, a, e, l);
        xfer(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, 1'b0, r, a, e, l);
        xfer(0, 1'b0, 32'h40, 4'b0000, 32'h0, 1'b0, r, a, e, l);
        checks++; if (r !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_0101: got %h want 11bb33dd", r); end
        xfer(0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 1'b0, r, a, e, l);
        checks++; if (!(a && !e)) begin errors++; $display("FAIL sel0_ack: ack=%b err=%b want 1 0", a, e); end
        xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (r !== 32'h11BB33DD) begin errors++; $display("FAIL sel0_nowrite: got %h want 11bb33dd", r); end
        xfer(0, 1'b1, 32'h40, 4'b1010, 32'h99887766, 1'b0, r, a, e, l);
        xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (r !== 32'h99BB77DD) begin errors++; $display("FAIL lanes_1010: got %h want 99bb77dd", r); end
    endtask

    task automatic test_wait_states;
        logic [31:0] r; bit a, e; int l;
        xfer(1, 1'b1, 32'h20, 4'hF, 32'h01234567, 1'b1, r, a, e, l);
        checks++; if (!(a && !e && l == 5)) begin errors++; $display("FAIL w3_write: ack=%b err=%b lat=%0d want 1 0 5", a, e, l); end
        xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, r, a, e, l);
        checks++; if (!(a && !e && l == 5)) begin errors++; $display("FAIL w3_read_lat: ack=%b err=%b lat=%0d want 1 0 5", a, e, l); end
        checks++; if (r !== 32'h01234567) begin errors++; $display("FAIL w3_read_data: got %h want 01234567", r); end
    endtask

    task automatic test_abort;
        logic [31:0] r; bit a, e; int l; int bad;
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
        @(posedge clk); #1;
        checks++; if (ack[1] !== 1'b0 || dat_o[1] !== 32'h0) begin errors++; $display("FAIL wait_outputs: ack=%b dat=%h want 0 0", ack[1], dat_o[1]); end
        release_bus(1);
        bad = 0;
        repeat (8) begin @(posedge clk); #1; if (ack[1] || err[1]) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_resp: got %0d responses want 0", bad); end
        xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (r !== 32'h01234567) begin errors++; $display("FAIL abort_mem: got %h want 01234567", r); end
    endtask

    task automatic test_err;
        logic [31:0] r; bit a, e; int l;
        xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, r, a, e, l);
`ifdef WB_SRAM_ERR_EN
        xfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (!(e && !a && r == 32'h0 && l == 2)) begin errors++; $display("FAIL err_range: ack=%b err=%b dat=%h lat=%0d want 0 1 0 2", a, e, r, l); end
        xfer(0, 1'b0, 32'h2, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (!(e && !a && r == 32'h0)) begin errors++; $display("FAIL err_align: ack=%b err=%b dat=%h want 0 1 0", a, e, r); end
        xfer(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b0, r, a, e, l);
        checks++; if (!(e && !a)) begin errors++; $display("FAIL err_write: ack=%b err=%b want 0 1", a, e); end
        xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL err_nowrite: got %h want cafef00d", r); end
`else
        xfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (!(a && !e && r == 32'hCAFEF00D)) begin errors++; $display("FAIL alias_range: ack=%b err=%b dat=%h want 1 0 cafef00d", a, e, r); end
        xfer(0, 1'b0, 32'h2, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (!(a && !e && r == 32'hCAFEF00D)) begin errors++; $display("FAIL alias_align: ack=%b err=%b dat=%h want 1 0 cafef00d", a, e, r); end
        xfer(0, 1'b1, 32'h1004, 4'hF, 32'h12345678, 1'b0, r, a, e, l);
        xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL alias_write: got %h want 12345678", r); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; bit a, e; int l; int bad;
        xfer(1, 1'b1, 32'h30, 4'hF, 32'h13579BDF, 1'b0, r, a, e, l);
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h30, 4'hF, 32'h5A5A5A5A);
        drive(0, 1'b0, 32'h10, 4'hF, 32'h0);
        @(posedge clk); #1;
        checks++; if (ack[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_ack: got %b want 1", ack[0]); end
        rst = 1'b1;
        #1;
        checks++; if (ack[0] !== 1'b0 || err[0] !== 1'b0 || dat_o[0] !== 32'h0) begin errors++; $display("FAIL rst_resp: ack=%b err=%b dat=%h want 0 0 0", ack[0], err[0], dat_o[0]); end
        checks++; if (ack[1] !== 1'b0 || err[1] !== 1'b0 || dat_o[1] !== 32'h0) begin errors++; $display("FAIL rst_wait: ack=%b err=%b dat=%h want 0 0 0", ack[1], err[1], dat_o[1]); end
        release_bus(0); release_bus(1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (6) begin @(posedge clk); #1; if (ack[1] || err[1] || ack[0] || err[0]) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_noresp: got %0d responses want 0", bad); end
        xfer(1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, r, a, e, l);
        checks++; if (r !== 32'h13579BDF) begin errors++; $display("FAIL rst_mem: got %h want 13579bdf", r); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_dat [2];
        logic [31:0] addrs [2];
        int n, last, bad_dat, bad_both, bad_pulse, bad_idle;
        bit prev;
        addrs[0] = 32'h10; exp_dat[0] = 32'hDEADBEEF;
        addrs[1] = 32'h40; exp_dat[1] = 32'h99BB77DD;
        n = 0; last = 0; bad_dat = 0; bad_both = 0; bad_pulse = 0; prev = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b0, addrs[0], 4'hF, 32'h0);
        for (int k = 2; k <= 60; k++) begin
            @(posedge clk); #1;
            if (ack[0] && err[0]) bad_both++;
            if (ack[0] && prev) bad_pulse++;
            prev = ack[0];
            if (ack[0]) begin
                if (dat_o[0] !== exp_dat[n % 2]) bad_dat++;
                n++;
                adr[0] = addrs[n % 2];
                if (n == 8) begin last = k; break; end
            end
        end
        release_bus(0);
        bad_idle = 0;
        repeat (4) begin @(posedge clk); #1; if (ack[0] || err[0]) bad_idle++; end
        checks++; if (n != 8 || last != 16) begin errors++; $display("FAIL b2b_count: acks=%0d last=%0d want 8 16", n, last); end
        checks++; if (bad_dat != 0) begin errors++; $display("FAIL b2b_data: got %0d bad words want 0", bad_dat); end
        checks++; if (bad_both != 0 || bad_pulse != 0) begin errors++; $display("FAIL b2b_pulse: both=%0d wide=%0d want 0 0", bad_both, bad_pulse); end
        checks++; if (bad_idle != 0) begin errors++; $display("FAIL b2b_idle: got %0d acks want 0", bad_idle); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait_states();
        test_abort();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
